// File: rtl/sass_seq_ctrl_pkg.sv
// rtl/sass_seq_ctrl_pkg.sv - shared types, sizes and note-coding helpers for the SaSS step sequencer
package sass_pkg;

   localparam int NUM_STEPS = 8;
   localparam int PTR_W     = $clog2(NUM_STEPS);
   localparam int NOTE_W    = 4;
   localparam int NUM_KEYS  = 15;

   localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

   // Encodings double as the mode_out code.
   typedef enum logic [1:0] {
      OFF    = 2'b00,
      RECORD = 2'b01,
      PLAY   = 2'b10
   } seq_state_t;

   // Lowest-index set key plus one, or NOTE_REST when nothing is set.
   function automatic logic [NOTE_W-1:0] key_code(input logic [NUM_KEYS-1:0] keys);
      logic [NOTE_W-1:0] code;
      code = NOTE_REST;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (keys[i]) begin
            code = NOTE_W'(i + 1);
         end
      end
      return code;
   endfunction

   function automatic logic [NUM_STEPS-1:0] one_hot(input logic [PTR_W-1:0] idx);
      logic [NUM_STEPS-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/sass_seq_ctrl_if.sv
// rtl/sass_seq_ctrl_if.sv - control-panel inputs and oscillator/LED outputs of the step sequencer
interface sass_seq_ctrl_if;
   import sass_pkg::*;

   logic [NUM_KEYS-1:0]  piano_keys;
   logic                 seq_power;
   logic                 tempo_select;
   logic                 seq_play;
   logic [NOTE_W-1:0]    note_out;
   logic [1:0]           mode_out;
   logic [NUM_STEPS-1:0] beat_led;
   logic                 seq_led_on;

   modport master (
      output piano_keys, seq_power, tempo_select, seq_play,
      input  note_out, mode_out, beat_led, seq_led_on
   );

   modport slave (
      input  piano_keys, seq_power, tempo_select, seq_play,
      output note_out, mode_out, beat_led, seq_led_on
   );

endinterface

// File: rtl/sass_seq_ctrl_tempo_tick.sv
// rtl/sass_seq_ctrl_tempo_tick.sv - step tick counter with slow/fast limit and restart on tempo change
module sass_tempo_tick #(
   parameter int STEP_TICKS_SLOW = 6_000_000,
   parameter int STEP_TICKS_FAST = 3_000_000
) (
   input  logic clk,
   input  logic n_rst,
   input  logic run_i,
   input  logic clear_i,
   input  logic fast_i,
   output logic tick_o
);

   localparam int CNT_W = $clog2(STEP_TICKS_SLOW);
   localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(STEP_TICKS_SLOW - 1);
   localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(STEP_TICKS_FAST - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_last;

   // Counter idles at zero outside PLAY so a fresh PLAY starts a full step.
   always_comb begin
      at_last = (cnt_q == (fast_i ? LAST_FAST : LAST_SLOW));
      tick_o  = run_i & ~clear_i & at_last;
      cnt_d   = cnt_q + 1'b1;
      if (!run_i || clear_i || at_last) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sass_seq_ctrl.sv
// rtl/sass_seq_ctrl.sv - SaSS step sequencer: live keys, 8-step record and two-tempo playback
// Define SASS_SEQ_LIVE_OVERLAY_EN to let held live keys override the pattern note in PLAY.
module sass_seq_ctrl
   import sass_pkg::*;
#(
   parameter int STEP_TICKS_SLOW = 6_000_000,
   parameter int STEP_TICKS_FAST = 3_000_000
) (
   input logic            clk,
   input logic            n_rst,
   sass_seq_ctrl_if.slave seq_if
);

   logic [NUM_KEYS-1:0]  keys_s_q, keys_p_q;
   logic                 power_s_q, power_p_q;
   logic                 play_s_q, play_p_q;
   logic                 tempo_s_q, tempo_p_q;

   seq_state_t           state_q, state_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     step_q, step_d;
   logic [NOTE_W-1:0]    pattern_q [NUM_STEPS];
   logic                 wr_en;

   logic                 power_rise, play_rise, key_rise, tempo_chg;
   logic [NOTE_W-1:0]    live_note, press_note;
   logic                 cnt_run, tick;

   logic [NOTE_W-1:0]    note_q, note_d;
   logic [1:0]           mode_q, mode_d;
   logic [NUM_STEPS-1:0] beat_q, beat_d;
   logic                 led_q, led_d;

   // Sample stage plus one cycle of history for edge detection.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         keys_s_q  <= '0;
         keys_p_q  <= '0;
         power_s_q <= 1'b0;
         power_p_q <= 1'b0;
         play_s_q  <= 1'b0;
         play_p_q  <= 1'b0;
         tempo_s_q <= 1'b0;
         tempo_p_q <= 1'b0;
      end else begin
         keys_s_q  <= seq_if.piano_keys;
         keys_p_q  <= keys_s_q;
         power_s_q <= seq_if.seq_power;
         power_p_q <= power_s_q;
         play_s_q  <= seq_if.seq_play;
         play_p_q  <= play_s_q;
         tempo_s_q <= seq_if.tempo_select;
         tempo_p_q <= tempo_s_q;
      end
   end

   always_comb begin
      power_rise = power_s_q & ~power_p_q;
      play_rise  = play_s_q & ~play_p_q;
      key_rise   = |(keys_s_q & ~keys_p_q);
      press_note = key_code(keys_s_q & ~keys_p_q);
      live_note  = key_code(keys_s_q);
      tempo_chg  = tempo_s_q ^ tempo_p_q;
      cnt_run    = (state_q == PLAY) & ~power_rise & ~play_rise;
   end

   sass_tempo_tick #(
      .STEP_TICKS_SLOW (STEP_TICKS_SLOW),
      .STEP_TICKS_FAST (STEP_TICKS_FAST)
   ) u_tempo_tick (
      .clk     (clk),
      .n_rst   (n_rst),
      .run_i   (cnt_run),
      .clear_i (tempo_chg),
      .fast_i  (tempo_s_q),
      .tick_o  (tick)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q  <= OFF;
         wr_ptr_q <= '0;
         step_q   <= '0;
         for (int i = 0; i < NUM_STEPS; i++) begin
            pattern_q[i] <= NOTE_REST;
         end
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         step_q   <= step_d;
         if (wr_en) begin
            pattern_q[wr_ptr_q] <= press_note;
         end
      end
   end

   // Power beats play beats key press; a press alongside a mode change is dropped.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      step_d   = step_q;
      wr_en    = 1'b0;
      case (state_q)
         OFF: begin
            if (power_rise) begin
               state_d  = RECORD;
               wr_ptr_d = '0;
            end
         end
         RECORD: begin
            if (power_rise) begin
               state_d = OFF;
            end else if (play_rise) begin
               state_d = PLAY;
               step_d  = '0;
            end else if (key_rise) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
         PLAY: begin
            if (power_rise) begin
               state_d = OFF;
            end else if (play_rise) begin
               state_d  = RECORD;
               wr_ptr_d = '0;
            end else if (tick) begin
               step_d = step_q + 1'b1;
            end
         end
         default: begin
            state_d = OFF;
         end
      endcase
   end

   always_comb begin
      note_d = live_note;
      mode_d = state_d;
      beat_d = '0;
      led_d  = (state_d != OFF);
      case (state_d)
         RECORD: begin
            beat_d = one_hot(wr_ptr_d);
         end
         PLAY: begin
            beat_d = one_hot(step_d);
`ifdef SASS_SEQ_LIVE_OVERLAY_EN
            note_d = (|keys_s_q) ? live_note : pattern_q[step_d];
`else
            note_d = pattern_q[step_d];
`endif
         end
         default: begin
            beat_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         note_q <= NOTE_REST;
         mode_q <= OFF;
         beat_q <= '0;
         led_q  <= 1'b0;
      end else begin
         note_q <= note_d;
         mode_q <= mode_d;
         beat_q <= beat_d;
         led_q  <= led_d;
      end
   end

   assign seq_if.note_out   = note_q;
   assign seq_if.mode_out   = mode_q;
   assign seq_if.beat_led   = beat_q;
   assign seq_if.seq_led_on = led_q;

endmodule

// File: tb/tb_sass_seq_ctrl.sv
// tb/tb_sass_seq_ctrl.sv - self-checking bench for sass_seq_ctrl with an abstract reference model
module tb_sass_seq_ctrl;

   localparam int SLOW = 8;
   localparam int FAST = 4;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   sass_seq_ctrl_if intf ();

   sass_seq_ctrl #(
      .STEP_TICKS_SLOW (SLOW),
      .STEP_TICKS_FAST (FAST)
   ) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .seq_if (intf)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [14:0] d_keys;
   logic        d_pwr, d_play, d_tempo;

   // Reference model: sequencer mode, pointers and pattern as plain integers.
   int          m_mode, m_wr, m_step, m_ticks;
   int          m_pat [8];
   logic [14:0] m_keys_c, m_keys_p;
   logic        m_pw_c, m_pw_p, m_pl_c, m_pl_p, m_tp_c, m_tp_p;
   logic [3:0]  e_note;
   logic [1:0]  e_mode;
   logic [7:0]  e_beat;
   logic        e_led;

   typedef struct {
      logic [14:0] keys;
      logic [3:0]  note;
   } live_vec_t;
   live_vec_t live_tab [6];

   function automatic int lowest_code(input logic [14:0] k);
      for (int i = 0; i < 15; i++) begin
         if (k[i]) return i + 1;
      end
      return 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_wr = 0; m_step = 0; m_ticks = 0;
      for (int i = 0; i < 8; i++) m_pat[i] = 0;
      m_keys_c = '0; m_keys_p = '0;
      m_pw_c = 0; m_pw_p = 0; m_pl_c = 0; m_pl_p = 0; m_tp_c = 0; m_tp_p = 0;
      e_note = '0; e_mode = '0; e_beat = '0; e_led = 1'b0;
   endtask

   task automatic model_step();
      logic [14:0] press;
      bit          pwr, ply;
      int          limit;
      press = m_keys_c & ~m_keys_p;
      pwr   = m_pw_c & !m_pw_p;
      ply   = m_pl_c & !m_pl_p;
      limit = m_tp_c ? FAST : SLOW;
      case (m_mode)
         0: if (pwr) begin m_mode = 1; m_wr = 0; end
         1: begin
            if (pwr) m_mode = 0;
            else if (ply) begin m_mode = 2; m_step = 0; m_ticks = 0; end
            else if (press != 0) begin
               m_pat[m_wr] = lowest_code(press);
               m_wr = (m_wr + 1) % 8;
            end
         end
         default: begin
            if (pwr) m_mode = 0;
            else if (ply) begin m_mode = 1; m_wr = 0; end
            else if (m_tp_c != m_tp_p) m_ticks = 0;
            else if (m_ticks == limit - 1) begin m_step = (m_step + 1) % 8; m_ticks = 0; end
            else m_ticks++;
         end
      endcase
      e_mode = 2'(m_mode);
      e_led  = (m_mode != 0);
      e_beat = (m_mode == 0) ? 8'h00 : (m_mode == 1) ? (8'h01 << m_wr) : (8'h01 << m_step);
      e_note = 4'(lowest_code(m_keys_c));
      if (m_mode == 2) begin
`ifdef SASS_SEQ_LIVE_OVERLAY_EN
         if (m_keys_c == 0) e_note = 4'(m_pat[m_step]);
`else
         e_note = 4'(m_pat[m_step]);
`endif
      end
      m_keys_p = m_keys_c; m_keys_c = d_keys;
      m_pw_p = m_pw_c; m_pw_c = d_pwr;
      m_pl_p = m_pl_c; m_pl_c = d_play;
      m_tp_p = m_tp_c; m_tp_c = d_tempo;
   endtask

   task automatic cycle();
      @(negedge clk);
      n_rst             = 1'b1;
      intf.piano_keys   = d_keys;
      intf.seq_power    = d_pwr;
      intf.seq_play     = d_play;
      intf.tempo_select = d_tempo;
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("model t=%0t", $time),
          32'({intf.note_out, intf.mode_out, intf.beat_led, intf.seq_led_on}),
          32'({e_note, e_mode, e_beat, e_led}));
   endtask

   task automatic do_reset(input int n);
      d_keys = '0; d_pwr = 1'b0; d_play = 1'b0; d_tempo = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_rst             = 1'b0;
         intf.piano_keys   = d_keys;
         intf.seq_power    = d_pwr;
         intf.seq_play     = d_play;
         intf.tempo_select = d_tempo;
         @(posedge clk);
      end
      model_reset();
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_note", 32'(intf.note_out), 0);
      chk("rst_mode", 32'(intf.mode_out), 0);
      chk("rst_beat", 32'(intf.beat_led), 0);
      chk("rst_led", 32'(intf.seq_led_on), 0);
   endtask

   task automatic rise_until(input bit pw, input bit pl, input logic [1:0] target);
      bit ok;
      ok = 1'b0;
      if (pw) d_pwr = 1'b1;
      if (pl) d_play = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         cycle();
         d_pwr  = 1'b0;
         d_play = 1'b0;
         if (intf.mode_out == target) ok = 1'b1;
      end
      chk("mode_reach", 32'(ok), 1);
   endtask

   task automatic press(input int idx);
      d_keys = 15'(1) << idx;
      cycle();
      cycle();
      d_keys = '0;
      cycle();
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      live_tab[0] = '{15'h0088, 4'd4};
      live_tab[1] = '{15'h0000, 4'd0};
      live_tab[2] = '{15'h4000, 4'd15};
      live_tab[3] = '{15'h4001, 4'd1};
      live_tab[4] = '{15'h7fff, 4'd1};
      live_tab[5] = '{15'h0200, 4'd10};

      n_rst = 1'b0;
      intf.piano_keys = '0; intf.seq_power = 1'b0; intf.seq_play = 1'b0; intf.tempo_select = 1'b0;
      do_reset(2);
      chk_reset_outputs();

      foreach (live_tab[i]) begin
         d_keys = live_tab[i].keys;
         cycle();
         cycle();
         chk($sformatf("live_note[%0d]", i), 32'(intf.note_out), 32'(live_tab[i].note));
         chk($sformatf("live_mode[%0d]", i), 32'(intf.mode_out), 0);
         chk($sformatf("live_beat[%0d]", i), 32'(intf.beat_led), 0);
      end
      d_keys = '0;
      cycle();

      rise_until(1'b1, 1'b0, 2'b01);
      chk("rec_beat0", 32'(intf.beat_led), 32'h01);
      chk("rec_led", 32'(intf.seq_led_on), 1);
      press(0); press(2); press(14);
      chk("rec_beat3", 32'(intf.beat_led), 32'h08);

      rise_until(1'b0, 1'b1, 2'b10);
      chk("play_k0", 32'(intf.note_out), 1);
      chk("play_beat_k0", 32'(intf.beat_led), 32'h01);
      for (int k = 1; k <= 32; k++) begin
         cycle();
         if (k == 7)  chk("play_k7", 32'(intf.note_out), 1);
         if (k == 8)  chk("play_k8", 32'(intf.note_out), 3);
         if (k == 8)  chk("play_beat_k8", 32'(intf.beat_led), 32'h02);
         if (k == 16) chk("play_k16", 32'(intf.note_out), 15);
         if (k == 24) chk("play_k24", 32'(intf.note_out), 0);
         if (k == 32) chk("play_beat_k32", 32'(intf.beat_led), 32'h10);
      end

      rise_until(1'b0, 1'b1, 2'b01);
      rise_until(1'b0, 1'b1, 2'b10);
      chk("tempo_k0", 32'(intf.note_out), 1);
      for (int k = 1; k <= 17; k++) begin
         if (k == 4) d_tempo = 1'b1;
         cycle();
         if (k == 8)  chk("tempo_k8", 32'(intf.note_out), 1);
         if (k == 9)  chk("tempo_k9", 32'(intf.note_out), 3);
         if (k == 12) chk("tempo_k12", 32'(intf.note_out), 3);
         if (k == 13) chk("tempo_k13", 32'(intf.note_out), 15);
         if (k == 17) chk("tempo_k17", 32'(intf.note_out), 0);
      end

      rise_until(1'b1, 1'b1, 2'b00);
      chk("abort_led", 32'(intf.seq_led_on), 0);
      chk("abort_beat", 32'(intf.beat_led), 0);
      d_tempo = 1'b0;
      rise_until(1'b1, 1'b0, 2'b01);
      chk("rerec_beat", 32'(intf.beat_led), 32'h01);
      rise_until(1'b0, 1'b1, 2'b10);
      chk("intact_k0", 32'(intf.note_out), 1);
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k == 8) chk("intact_k8", 32'(intf.note_out), 3);
      end

      rise_until(1'b0, 1'b1, 2'b01);
      for (int idx = 1; idx <= 9; idx++) press(idx);
      chk("wrap_beat", 32'(intf.beat_led), 32'h02);
      rise_until(1'b0, 1'b1, 2'b10);
      chk("wrap_k0", 32'(intf.note_out), 10);
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k == 8) chk("wrap_k8", 32'(intf.note_out), 3);
      end

      rise_until(1'b0, 1'b1, 2'b01);
      rise_until(1'b0, 1'b1, 2'b10);
      d_keys = 15'h0020;
      for (int k = 1; k <= 3; k++) begin
         cycle();
`ifdef SASS_SEQ_LIVE_OVERLAY_EN
         if (k == 3) chk("overlay_note", 32'(intf.note_out), 6);
`else
         if (k == 3) chk("overlay_note", 32'(intf.note_out), 10);
`endif
      end
      d_keys = '0;
      cycle();
      cycle();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0:       d_keys = '0;
               1, 2:    d_keys = 15'(1) << $urandom_range(0, 14);
               default: d_keys = 15'($urandom);
            endcase
         end
         if ($urandom_range(0, 149) == 0) d_pwr = ~d_pwr;
         if ($urandom_range(0, 29) == 0) d_play = ~d_play;
         if ($urandom_range(0, 79) == 0) d_tempo = ~d_tempo;
         cycle();
      end

      do_reset(2);
      chk_reset_outputs();
      rise_until(1'b1, 1'b0, 2'b01);
      rise_until(1'b0, 1'b1, 2'b10);
      chk("cleared_k0", 32'(intf.note_out), 0);
      for (int k = 1; k <= 56; k++) begin
         cycle();
         if (k % 8 == 0) chk($sformatf("cleared_k%0d", k), 32'(intf.note_out), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
